irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Platform-level interrupt arbiter. It collects up to `NUM_SRC` external interrupt lines, applies per-source enable and priority, and presents a single `irq_external_o` to the CSR `mip` external-pending bit. The trap handler takes the interrupt by claiming the winning source ID through a small register port, and releases it by writing a completion. The block sits between peripherals and the core CSR/interrupt control logic.

## Interface
- `NUM_SRC`, default 8: number of sources, range 1..8. Source ID `k` (1..NUM_SRC) is `irq_src_i[k-1]`. ID 0 means "none".
- `PRIO_W`, default 3: priority width. Priority 0 means never interrupt.
- `clk_i`  in  1: single clock.
- `rst_ni`  in  1: asynchronous active-low reset.
- `irq_src_i`  in  NUM_SRC: level interrupt lines; may be asynchronous.
- `we_i`  in  1: register write strobe.
- `re_i`  in  1: register read strobe.
- `addr_i`  in  4: word index.
- `wdata_i`  in  32: write data.
- `rdata_o`  out  32: registered read data.
- `irq_external_o`  out  1: registered request to CSR `mip_external`.

## Operation
- Register map (word index):
  - 0..NUM_SRC-1: PRIO of ID index+1, R/W, bits [PRIO_W-1:0].
  - 8: PENDING, RO; bit k-1 is ID k.
  - 9: ENABLE, R/W.
  - 10: THRESHOLD, R/W.
  - 11: CLAIM on read, COMPLETE on write.
  - Unmapped indices read 0 and ignore writes.
- Per-source gateway FSM, states IDLE / PENDING / IN_SERVICE:
  - IDLE→PENDING when the synchronized line is 1.
  - PENDING→IN_SERVICE when this ID is claimed.
  - IN_SERVICE→IDLE on COMPLETE with a matching ID. If the line is still high, the next cycle re-enters PENDING (level semantics).
  - A COMPLETE whose ID is not IN_SERVICE is ignored.
- Arbiter:
  - Candidates are sources with PENDING, enabled, and priority > effective threshold.
  - The highest priority wins. Equal priorities go to the lowest ID.
  - The result is registered in `best_id` and `best_prio`.
  - `irq_external_o` = (best_id != 0), registered.
- Claim (re_i, addr 11):
  - `rdata_o` ← `best_id`.
  - That source goes to IN_SERVICE in the same edge.
  - If `best_id` = 0, the claim returns 0 and nothing changes.
- If `we_i` and `re_i` are both asserted, only the write is performed. `rdata_o` holds its value.
- No write side effects other than COMPLETE. PENDING is not writable.

## Timing
- Reset values:
  - `rdata_o` = 0, `irq_external_o` = 0.
  - All PRIO, ENABLE and THRESHOLD = 0.
  - All gateways IDLE. Synchronizers 0. `best_id` = 0.
- `irq_src_i` passes through a 2-flop synchronizer. For a line high before edge N:
  - sync2 = 1 after edge N+1.
  - PENDING after edge N+2.
  - `irq_external_o` = 1 after edge N+3.
- Read latency is 1 cycle. `rdata_o` is valid after the edge that samples `re_i`, and holds until the next read.
- After a claim at edge N:
  - `best_id` and `irq_external_o` reflect the remaining candidates after edge N+1.
  - A second claim issued at N+1 may still return the stale ID. Software must not issue back-to-back claims; the testbench checks that such a claim returns the stale ID and causes no state change.
- COMPLETE at edge N: the gateway is IDLE after N; it is PENDING again after N+1 if the line is still high.
- Register writes to PRIO, ENABLE or THRESHOLD affect `irq_external_o` 1 cycle later.
- Asserting `rst_ni` mid-operation clears everything immediately (asynchronously). Deassertion is synchronous to `clk_i` at the top level.

## Configuration
- `IRQ_ARB_THRESHOLD_EN` defined:
  - THRESHOLD is a PRIO_W-bit R/W register.
  - Candidates require priority > THRESHOLD.
- Not defined:
  - THRESHOLD reads 0 and ignores writes.
  - The effective threshold is 0.
  - No threshold flops are synthesized.

## Test plan
- Reset, then raise `irq_src_i[2]` with PRIO3=5 and ENABLE=0x04 → `irq_external_o` = 1 exactly 3 edges later. A CLAIM read returns 3, and `irq_external_o` = 0 one cycle after the claim.
- ID 2 at prio 4 and ID 5 at prio 4 both pending, plus ID 7 at prio 2 → first claim returns 2. After COMPLETE(2) with the line low, the next claim returns 5, then 7, then 0.
- The line stays high through claim and COMPLETE(1) → PENDING bit 0 is re-set 1 cycle after the complete, and `irq_external_o` rises again 1 cycle later.
- COMPLETE(4) while ID 4 is not in service, and a claim with no candidates → no state change, and the claim returns 0.
- With `IRQ_ARB_THRESHOLD_EN`, THRESHOLD=5 and an ID 1 at prio 5 pending → `irq_external_o` = 0. Setting THRESHOLD=4 raises `irq_external_o` 1 cycle later. Without the macro, THRESHOLD reads 0 after a write of 7.
- Pull `rst_ni` low while ID 3 is IN_SERVICE and `irq_external_o` = 1 → all outputs are 0 immediately, and PENDING, ENABLE and PRIO read 0 after release.

Source files
------------

// File: rtl/irq_arbiter.sv
// Platform-level interrupt arbiter: per-source gateways, priority arbitration, claim/complete port.
// Optional feature macro: IRQ_ARB_THRESHOLD_EN (programmable priority threshold).
module irq_arbiter #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [3:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               irq_external_o
);

  typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_INSV} gw_state_e;

  localparam logic [3:0] ADDR_PEND  = 4'd8;
  localparam logic [3:0] ADDR_EN    = 4'd9;
  localparam logic [3:0] ADDR_THR   = 4'd10;
  localparam logic [3:0] ADDR_CLAIM = 4'd11;

  logic [NUM_SRC-1:0] sync1, sync2, enable, pending_vec;
  gw_state_e          gw   [NUM_SRC];
  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [PRIO_W-1:0]  thr_eff, best_prio, win_prio;
  logic [3:0]         best_id, win_id;
  logic               rd_en, claim, complete;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  assign rd_en        = re_i & ~we_i;
  assign claim        = rd_en && (addr_i == ADDR_CLAIM);
  assign complete     = we_i && (addr_i == ADDR_CLAIM);
  assign unused_wdata = ^wdata_i;

`ifdef IRQ_ARB_THRESHOLD_EN
  logic [PRIO_W-1:0] threshold;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) threshold <= '0;
    else if (we_i && (addr_i == ADDR_THR)) threshold <= wdata_i[PRIO_W-1:0];
  end
  assign thr_eff = threshold;
`else
  assign thr_eff = '0;
`endif

  always_comb begin
    pending_vec = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) pending_vec[k] = (gw[k] == GW_PEND);
  end

  // Strict '>' while scanning upward keeps the lowest ID on equal priority.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (pending_vec[k] && enable[k] && (prio[k] > thr_eff) && (prio[k] > win_prio)) begin
        win_id   = 4'(k + 1);
        win_prio = prio[k];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++)
      if (addr_i == 4'(k)) rd_mux = 32'(prio[k]);
    case (addr_i)
      ADDR_PEND:  rd_mux = 32'(pending_vec);
      ADDR_EN:    rd_mux = 32'(enable);
      ADDR_THR:   rd_mux = 32'(thr_eff);
      ADDR_CLAIM: rd_mux = 32'(best_id);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1          <= '0;
      sync2          <= '0;
      enable         <= '0;
      best_id        <= '0;
      best_prio      <= '0;
      rdata_o        <= '0;
      irq_external_o <= 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        prio[k] <= '0;
        gw[k]   <= GW_IDLE;
      end
    end else begin
      sync1          <= irq_src_i;
      sync2          <= sync1;
      best_id        <= win_id;
      best_prio      <= win_prio;
      irq_external_o <= (win_id != '0);
      if (rd_en) rdata_o <= rd_mux;
      if (we_i) begin
        for (int unsigned k = 0; k < NUM_SRC; k++)
          if (addr_i == 4'(k)) prio[k] <= wdata_i[PRIO_W-1:0];
        if (addr_i == ADDR_EN) enable <= wdata_i[NUM_SRC-1:0];
      end
      // Claims act on the registered winner, so a back-to-back claim sees a stale ID
      // whose gateway is already in service and therefore changes nothing.
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        case (gw[k])
          GW_IDLE: if (sync2[k]) gw[k] <= GW_PEND;
          GW_PEND: if (claim && (best_prio != '0) && (best_id == 4'(k + 1))) gw[k] <= GW_INSV;
          GW_INSV: if (complete && (wdata_i[3:0] == 4'(k + 1))) gw[k] <= GW_IDLE;
          default: gw[k] <= GW_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: register-access vector table plus directed
// sequences for synchronizer latency, claim/complete, tie-break, threshold and reset.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  irq_src = '0;
  logic        we = 1'b0, re = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq_ext;

  int checks = 0;
  int errors = 0;

`ifdef IRQ_ARB_THRESHOLD_EN
  localparam logic [31:0] THR_EXP = 32'd7;
`else
  localparam logic [31:0] THR_EXP = 32'd0;
`endif

  irq_arbiter #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .irq_src_i(irq_src), .we_i(we), .re_i(re),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .irq_external_o(irq_ext)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic r, logic [3:0] a, logic [31:0] d, logic c, logic [31:0] e);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d; v.chk = c; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    @(posedge clk); #1;
    re = 1'b0;
    d = rdata;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; we = 1'b0; re = 1'b0; irq_src = '0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] d;

    vecs.push_back(mk(1, 0, 4'd0,  32'hFFFF_FFFD, 0, 0));
    vecs.push_back(mk(0, 1, 4'd0,  0,             1, 32'd5));
    vecs.push_back(mk(1, 0, 4'd7,  32'd6,         0, 0));
    vecs.push_back(mk(0, 1, 4'd7,  0,             1, 32'd6));
    vecs.push_back(mk(1, 0, 4'd9,  32'hFFFF_FFA5, 0, 0));
    vecs.push_back(mk(0, 1, 4'd9,  0,             1, 32'hA5));
    vecs.push_back(mk(1, 0, 4'd10, 32'd7,         0, 0));
    vecs.push_back(mk(0, 1, 4'd10, 0,             1, THR_EXP));
    vecs.push_back(mk(1, 0, 4'd12, 32'hDEAD,      0, 0));
    vecs.push_back(mk(0, 1, 4'd12, 0,             1, 32'd0));
    vecs.push_back(mk(0, 1, 4'd15, 0,             1, 32'd0));
    vecs.push_back(mk(0, 1, 4'd8,  0,             1, 32'd0));
    vecs.push_back(mk(0, 1, 4'd7,  0,             1, 32'd6));
    vecs.push_back(mk(1, 1, 4'd3,  32'd4,         1, 32'd6));
    vecs.push_back(mk(0, 1, 4'd3,  0,             1, 32'd4));
    vecs.push_back(mk(1, 0, 4'd11, 32'd1,         0, 0));
    vecs.push_back(mk(0, 1, 4'd8,  0,             1, 32'd0));
    vecs.push_back(mk(0, 1, 4'd11, 0,             1, 32'd0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 0);
    check("reset_irq", 32'(irq_ext), 0);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr; wdata = vecs[i].wdata;
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0;
      if (vecs[i].chk) check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end

    // Synchronizer latency and single claim
    do_reset();
    wr(4'd2, 32'd5);
    wr(4'd9, 32'h04);
    irq_src = 8'h04;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("latency_edge%0d", i), 32'(irq_ext), (i == 3) ? 32'd1 : 32'd0);
    end
    rd(4'd11, d);
    check("claim_id3", d, 3);
    check("irq_stale_after_claim", 32'(irq_ext), 1);
    idle(1);
    check("irq_drop_after_claim", 32'(irq_ext), 0);
    irq_src = '0;
    wr(4'd11, 32'd3);

    // Priority, tie-break, back-to-back claim
    do_reset();
    wr(4'd1, 32'd4);
    wr(4'd4, 32'd4);
    wr(4'd6, 32'd2);
    wr(4'd9, 32'h52);
    irq_src = 8'h52;
    idle(4);
    irq_src = '0;
    idle(1);
    check("tie_irq", 32'(irq_ext), 1);
    rd(4'd11, d);
    check("claim_tie_id2", d, 2);
    rd(4'd11, d);
    check("claim_b2b_stale", d, 2);
    rd(4'd8, d);
    check("pending_after_b2b", d, 32'h50);
    wr(4'd11, 32'd2);
    rd(4'd11, d);
    check("claim_id5", d, 5);
    idle(1);
    rd(4'd11, d);
    check("claim_id7", d, 7);
    idle(1);
    rd(4'd11, d);
    check("claim_none", d, 0);
    check("irq_none", 32'(irq_ext), 0);

    // Level re-trigger after complete
    do_reset();
    wr(4'd0, 32'd3);
    wr(4'd9, 32'h01);
    irq_src = 8'h01;
    idle(4);
    rd(4'd11, d);
    check("claim_id1", d, 1);
    idle(1);
    check("irq_low_insv", 32'(irq_ext), 0);
    wr(4'd11, 32'd1);
    rd(4'd8, d);
    check("pend_idle_after_cmp", d, 0);
    check("irq_low_after_cmp", 32'(irq_ext), 0);
    rd(4'd8, d);
    check("pend_reset_after_cmp", d, 1);
    check("irq_reraise", 32'(irq_ext), 1);
    irq_src = '0;
    rd(4'd11, d);
    check("claim_id1_again", d, 1);
    idle(1);
    wr(4'd11, 32'd1);

    // Complete of a non-serviced ID, claim with no candidates
    do_reset();
    wr(4'd3, 32'd2);
    wr(4'd9, 32'h08);
    irq_src = 8'h08;
    idle(4);
    irq_src = '0;
    wr(4'd11, 32'd4);
    rd(4'd8, d);
    check("pend_after_bad_cmp", d, 32'h08);
    rd(4'd11, d);
    check("claim_id4", d, 4);
    idle(1);
    rd(4'd11, d);
    check("claim_empty", d, 0);
    rd(4'd8, d);
    check("pend_empty", d, 0);

    // Threshold
    do_reset();
`ifdef IRQ_ARB_THRESHOLD_EN
    wr(4'd0, 32'd5);
    wr(4'd9, 32'h01);
    wr(4'd10, 32'd5);
    irq_src = 8'h01;
    idle(5);
    check("thr_blocks", 32'(irq_ext), 0);
    wr(4'd10, 32'd4);
    check("thr_write_edge", 32'(irq_ext), 0);
    idle(1);
    check("thr_lowered", 32'(irq_ext), 1);
    irq_src = '0;
`else
    wr(4'd10, 32'd7);
    rd(4'd10, d);
    check("thr_absent", d, 0);
`endif

    // Asynchronous reset mid-service
    do_reset();
    wr(4'd0, 32'd1);
    wr(4'd2, 32'd5);
    wr(4'd9, 32'h05);
    irq_src = 8'h05;
    idle(4);
    irq_src = '0;
    idle(1);
    rd(4'd11, d);
    check("claim_before_rst", d, 3);
    idle(2);
    check("irq_before_rst", 32'(irq_ext), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 0);
    check("async_rst_irq", 32'(irq_ext), 0);
    @(posedge clk); #1 rst_ni = 1'b1;
    rd(4'd8, d);
    check("rst_pending", d, 0);
    rd(4'd9, d);
    check("rst_enable", d, 0);
    rd(4'd0, d);
    check("rst_prio0", d, 0);
    rd(4'd2, d);
    check("rst_prio2", d, 0);
    rd(4'd11, d);
    check("rst_claim", d, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
